// File: rtl/packet_tx_ctrl_pkg.sv
// Shared definitions for the packet transmit path: FSM encoding, index sizing
// and the XOR checksum step also used by the receive-side checker.
package packet_tx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widest word the checksum helper accepts; callers zero-extend into it.
    localparam int CKSUM_MAX_W = 64;

    // Bits needed to hold indices 0..num_bytes (the checksum word is index num_bytes).
    function automatic int idx_width(input int num_bytes);
        return (num_bytes < 1) ? 1 : $clog2(num_bytes + 1);
    endfunction

    function automatic logic [CKSUM_MAX_W-1:0] xor_cksum_step(
        input logic [CKSUM_MAX_W-1:0] acc,
        input logic [CKSUM_MAX_W-1:0] word
    );
        return acc ^ word;
    endfunction

endpackage

// File: rtl/packet_tx_ctrl.sv
// Serialises a latched NUM_BYTES packet MSB byte first over a valid/tx_done
// handshake, optionally closing it with an XOR checksum word.
module packet_tx_ctrl
    import packet_tx_ctrl_pkg::*;
#(
    parameter int NUM_BYTES       = 8,
    parameter int BYTE_W          = 8,
    parameter int VALID_CYCLES    = 2,
    parameter int APPEND_CHECKSUM = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_BYTES*BYTE_W-1:0]      data_in,
    input  logic                             tx_done,
    output logic                             valid,
    output logic [BYTE_W-1:0]                data_out,
    output logic                             busy,
    output logic [idx_width(NUM_BYTES)-1:0]  byte_idx,
    output logic                             packet_done
);

    localparam int PKT_W     = NUM_BYTES * BYTE_W;
    localparam int IDX_W     = idx_width(NUM_BYTES);
    localparam int VCNT_W    = (VALID_CYCLES < 2) ? 1 : $clog2(VALID_CYCLES + 1);
    localparam int NUM_WORDS = NUM_BYTES + ((APPEND_CHECKSUM != 0) ? 1 : 0);

    state_t              r_state;
    logic [PKT_W-1:0]    r_shift;
    logic [BYTE_W-1:0]   r_data_out;
    logic [IDX_W-1:0]    r_byte_idx;
    logic [VCNT_W-1:0]   r_vcnt;
    logic [BYTE_W-1:0]   r_acc;

    state_t              w_state_nxt;
    logic [BYTE_W-1:0]   w_data_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [VCNT_W-1:0]   w_vcnt_nxt;
    logic [BYTE_W-1:0]   w_acc_nxt;
    logic                w_load;
    logic                w_advance;
    logic [PKT_W-1:0]    w_shift_adv;
    logic [BYTE_W-1:0]   w_acc_upd;
    logic                w_is_payload;
    logic                w_last_payload;
    logic                w_last_word;

    assign w_shift_adv    = r_shift << BYTE_W;
    assign w_is_payload   = (r_byte_idx < IDX_W'(NUM_BYTES));
    assign w_last_payload = (r_byte_idx == IDX_W'(NUM_BYTES - 1));
    assign w_last_word    = (r_byte_idx == IDX_W'(NUM_WORDS - 1));

    // The checksum word itself is never folded back into the accumulator.
    assign w_acc_upd = w_is_payload
        ? BYTE_W'(xor_cksum_step(CKSUM_MAX_W'(r_acc), CKSUM_MAX_W'(r_data_out)))
        : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data_out;
        w_idx_nxt   = r_byte_idx;
        w_vcnt_nxt  = r_vcnt;
        w_acc_nxt   = r_acc;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                    w_data_nxt  = data_in[PKT_W-1 -: BYTE_W];
                    w_idx_nxt   = '0;
                    w_vcnt_nxt  = '0;
                    w_acc_nxt   = '0;
                end
            end
            SEND, WAIT: begin
                if (tx_done) begin
                    w_acc_nxt = w_acc_upd;
                    if (w_last_word) begin
                        w_state_nxt = DONE;
                    end else begin
                        // Next word goes straight out with a fresh valid window.
                        w_advance   = 1'b1;
                        w_state_nxt = SEND;
                        w_idx_nxt   = r_byte_idx + IDX_W'(1);
                        w_vcnt_nxt  = '0;
                        w_data_nxt  = w_last_payload ? w_acc_upd
                                                     : w_shift_adv[PKT_W-1 -: BYTE_W];
                    end
                end else if (r_state == SEND) begin
                    if (r_vcnt == VCNT_W'(VALID_CYCLES - 1)) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_vcnt_nxt = r_vcnt + VCNT_W'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_data_out <= '0;
            r_byte_idx <= '0;
            r_vcnt     <= '0;
            r_acc      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data_out <= w_data_nxt;
            r_byte_idx <= w_idx_nxt;
            r_vcnt     <= w_vcnt_nxt;
            r_acc      <= w_acc_nxt;
        end
    end

    // Packet payload is pure data; a new start always reloads it.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_shift <= data_in;
        end else if (w_advance) begin
            r_shift <= w_shift_adv;
        end
    end

    assign valid       = (r_state == SEND);
    assign busy        = (r_state != IDLE);
    assign packet_done = (r_state == DONE);
    assign data_out    = r_data_out;
    assign byte_idx    = r_byte_idx;

endmodule

// File: tb/tb_packet_tx_ctrl.sv
// Directed bench for packet_tx_ctrl: table-driven packets on the default
// configuration plus hand-written corner sequences on three parameter sets.
module tb_packet_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tx_done;
    logic [63:0] data_in;
    int          sel;

    logic       v0, bz0, pd0;
    logic [7:0] d0;
    logic [3:0] i0;
    logic       v1, bz1, pd1;
    logic [7:0] d1;
    logic [2:0] i1;
    logic       v2, bz2, pd2;
    logic [7:0] d2;
    logic [0:0] i2;

    logic       m_valid, m_busy, m_pdone;
    logic [7:0] m_data, m_idx;

    int n_cmp = 0;
    int n_err = 0;
    int pd_count = 0;
    int pd_base = 0;

    always #5 clk = ~clk;

    packet_tx_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .data_in(data_in),
        .tx_done(tx_done && sel == 0), .valid(v0), .data_out(d0), .busy(bz0),
        .byte_idx(i0), .packet_done(pd0)
    );

    packet_tx_ctrl #(.NUM_BYTES(4), .BYTE_W(8), .VALID_CYCLES(2), .APPEND_CHECKSUM(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .data_in(data_in[31:0]),
        .tx_done(tx_done && sel == 1), .valid(v1), .data_out(d1), .busy(bz1),
        .byte_idx(i1), .packet_done(pd1)
    );

    packet_tx_ctrl #(.NUM_BYTES(1), .BYTE_W(8), .VALID_CYCLES(1), .APPEND_CHECKSUM(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start && sel == 2), .data_in(data_in[7:0]),
        .tx_done(tx_done && sel == 2), .valid(v2), .data_out(d2), .busy(bz2),
        .byte_idx(i2), .packet_done(pd2)
    );

    always_comb begin
        m_valid = v2; m_busy = bz2; m_pdone = pd2; m_data = d2; m_idx = {7'd0, i2};
        if (sel == 0) begin
            m_valid = v0; m_busy = bz0; m_pdone = pd0; m_data = d0; m_idx = {4'd0, i0};
        end else if (sel == 1) begin
            m_valid = v1; m_busy = bz1; m_pdone = pd1; m_data = d1; m_idx = {5'd0, i1};
        end
    end

    always @(posedge clk) if (m_pdone) pd_count <= pd_count + 1;

    typedef struct packed {
        logic [63:0] pkt;
        logic [7:0]  word;
        logic [3:0]  idx;
        logic        last;
    } vec_t;

    localparam logic [63:0] P1 = 64'h1101_00FF_EAFF_1152;
    localparam logic [63:0] P2 = 64'h0123_4567_89AB_CDEF;
    logic [7:0] p1_w [9];
    logic [7:0] p2_w [9];
    vec_t       vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_pkt(input logic [63:0] pkt);
        data_in = pkt;
        start   = 1'b1;
        pd_base = pd_count;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the word, checks it, counts valid-high cycles over `delay`
    // cycles, then pulses tx_done. Returns on the cycle after that edge.
    task automatic do_word(input logic [7:0] w, input int idx, input int delay,
                           input int exp_vc, input bit poke);
        int vc;
        int waited;
        waited = 0;
        while (!m_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("word_valid", {63'd0, m_valid}, 64'd1);
        check("word_data", {56'd0, m_data}, {56'd0, w});
        check("word_idx", {56'd0, m_idx}, 64'(idx));
        vc = 0;
        for (int k = 0; k < delay; k++) begin
            if (m_valid) vc++;
            if (poke) start = (k == 3);
            @(negedge clk);
        end
        start = 1'b0;
        if (delay > 0) check("valid_cycles", 64'(vc), 64'(exp_vc));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic check_done();
        check("done_pdone", {63'd0, m_pdone}, 64'd1);
        check("done_valid", {63'd0, m_valid}, 64'd0);
        check("done_busy", {63'd0, m_busy}, 64'd1);
        @(negedge clk);
        check("idle_pdone", {63'd0, m_pdone}, 64'd0);
        check("idle_busy", {63'd0, m_busy}, 64'd0);
        check("idle_idx", {56'd0, m_idx}, 64'd0);
        check("pdone_pulses", 64'(pd_count - pd_base), 64'd1);
    endtask

    initial begin
        p1_w = '{8'h11, 8'h01, 8'h00, 8'hFF, 8'hEA, 8'hFF, 8'h11, 8'h52, 8'hB9};
        p2_w = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};
        for (int i = 0; i < 9; i++) begin
            vecs[i]     = '{P1, p1_w[i], 4'(i), (i == 8)};
            vecs[i + 9] = '{P2, p2_w[i], 4'(i), (i == 8)};
        end

        rst = 1'b1; start = 1'b0; tx_done = 1'b0; data_in = '0; sel = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, v0}, 64'd0);
        check("rst_data", {56'd0, d0}, 64'd0);
        check("rst_busy", {63'd0, bz0}, 64'd0);
        check("rst_idx", {60'd0, i0}, 64'd0);
        check("rst_pdone", {63'd0, pd0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: P1, then P2 with data_in cleared after start and a start poke mid-packet.
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].idx == 4'd0) begin
                start_pkt(vecs[i].pkt);
                if (i >= 9) data_in = '0;
                check("start_busy", {63'd0, m_busy}, 64'd1);
            end
            do_word(vecs[i].word, int'(vecs[i].idx), 10, 2, (i == 13));
            if (vecs[i].last) check_done();
        end

        // tx_done in the first SEND cycle of word 2.
        start_pkt(P1);
        do_word(p1_w[0], 0, 10, 2, 1'b0);
        do_word(p1_w[1], 1, 10, 2, 1'b0);
        do_word(p1_w[2], 2, 0, 0, 1'b0);
        check("early_valid", {63'd0, m_valid}, 64'd1);
        check("early_idx", {56'd0, m_idx}, 64'd3);
        check("early_data", {56'd0, m_data}, 64'hFF);
        for (int j = 3; j < 9; j++) do_word(p1_w[j], j, 10, 2, 1'b0);
        check_done();

        // Asynchronous reset while waiting on word 5, then a clean resend.
        start_pkt(P1);
        for (int j = 0; j < 5; j++) do_word(p1_w[j], j, 10, 2, 1'b0);
        check("w5_data", {56'd0, m_data}, 64'hFF);
        repeat (3) @(negedge clk);
        check("w5_waiting", {63'd0, m_valid}, 64'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, m_valid}, 64'd0);
        check("arst_data", {56'd0, m_data}, 64'd0);
        check("arst_busy", {63'd0, m_busy}, 64'd0);
        check("arst_idx", {56'd0, m_idx}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_stays_idle", {63'd0, m_busy}, 64'd0);
        start_pkt(P1);
        for (int j = 0; j < 9; j++) do_word(p1_w[j], j, 10, 2, 1'b0);
        check_done();

        // start held high through DONE: one IDLE cycle, then the next packet.
        data_in = P2;
        start   = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 9; j++) begin
            do_word(p2_w[j], j, 10, 2, 1'b0);
            start = 1'b1;
        end
        check("held_pdone", {63'd0, m_pdone}, 64'd1);
        @(negedge clk);
        check("held_gap_busy", {63'd0, m_busy}, 64'd0);
        check("held_gap_valid", {63'd0, m_valid}, 64'd0);
        @(negedge clk);
        start   = 1'b0;
        pd_base = pd_count;
        check("held_restart_valid", {63'd0, m_valid}, 64'd1);
        for (int j = 0; j < 9; j++) do_word(p2_w[j], j, 10, 2, 1'b0);
        check_done();

        // Four bytes, no checksum.
        sel = 1;
        @(negedge clk);
        start_pkt(64'h0000_0000_DEAD_BEEF);
        do_word(8'hDE, 0, 10, 2, 1'b0);
        do_word(8'hAD, 1, 10, 2, 1'b0);
        do_word(8'hBE, 2, 10, 2, 1'b0);
        do_word(8'hEF, 3, 10, 2, 1'b0);
        check_done();

        // One byte, one-cycle valid, checksum echoes the byte.
        sel = 2;
        @(negedge clk);
        start_pkt(64'h0000_0000_0000_00A5);
        do_word(8'hA5, 0, 10, 1, 1'b0);
        do_word(8'hA5, 1, 10, 1, 1'b0);
        check_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
